// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard/stall controller.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Width of the mul/div down-counter; never narrower than one bit.
    function automatic int unsigned md_cnt_w(input int unsigned lat);
        int unsigned w;
        w = $clog2(lat);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Three saturating performance counters driven by single-cycle increment strobes.
module hazard_perf_counters #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_load_use,
    input  logic         inc_md,
    input  logic         inc_flush,
    output logic [W-1:0] load_use_stalls,
    output logic [W-1:0] md_stall_cycles,
    output logic [W-1:0] flush_count
);

    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] MAX = '1;

    // Counters hold at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_use_stalls <= '0;
            md_stall_cycles <= '0;
            flush_count     <= '0;
        end else begin
            if (inc_load_use && (load_use_stalls != MAX)) load_use_stalls <= load_use_stalls + ONE;
            if (inc_md && (md_stall_cycles != MAX))       md_stall_cycles <= md_stall_cycles + ONE;
            if (inc_flush && (flush_count != MAX))        flush_count     <= flush_count + ONE;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detection and stall control: load-use, mul/div occupancy, taken-branch flush.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        IfIdRs,
    input  logic [4:0]        IfIdRt,
    input  logic              IfIdUsesRt,
    input  logic              IdExMemRead,
    input  logic [4:0]        IdExRt,
    input  logic              MdStart,
    input  logic              BranchTaken,
    output logic              PcWrite,
    output logic              IfIdWrite,
    output logic              IfIdFlush,
    output logic              IdExFlush,
    output logic              IdExHold,
    output logic              ExMemBubble,
    output logic              MdBusy,
    output logic [PERF_W-1:0] LoadUseStalls,
    output logic [PERF_W-1:0] MdStallCycles,
    output logic [PERF_W-1:0] FlushCount
);

    localparam int unsigned       CNT_W    = md_cnt_w(MD_LATENCY);
    localparam bit                MD_SHORT = (MD_LATENCY <= 2);
    localparam logic [CNT_W-1:0]  MD_LOAD  = CNT_W'((MD_LATENCY > 2) ? (MD_LATENCY - 3) : 0);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] md_cnt;
    logic [CNT_W-1:0] md_cnt_nxt;
    logic             load_use;
    logic             inc_load_use;
    logic             inc_md;
    logic             inc_flush;

    assign load_use = IdExMemRead && (IdExRt != REG_ZERO) &&
                      ((IdExRt == IfIdRs) || (IfIdUsesRt && (IdExRt == IfIdRt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    // Mealy next-state and control outputs; EX is frozen while in MD_WAIT.
    always_comb begin
        state_nxt    = state;
        md_cnt_nxt   = md_cnt;
        PcWrite      = 1'b1;
        IfIdWrite    = 1'b1;
        IfIdFlush    = 1'b0;
        IdExFlush    = 1'b0;
        IdExHold     = 1'b0;
        ExMemBubble  = 1'b0;
        MdBusy       = 1'b0;
        inc_load_use = 1'b0;
        inc_md       = 1'b0;
        inc_flush    = 1'b0;

        case (state)
            RUN: begin
                if (BranchTaken) begin
                    IfIdFlush = 1'b1;
                    IdExFlush = 1'b1;
                    inc_flush = 1'b1;
                end else if (MdStart) begin
                    PcWrite     = 1'b0;
                    IfIdWrite   = 1'b0;
                    IdExHold    = 1'b1;
                    ExMemBubble = 1'b1;
                    inc_md      = 1'b1;
                    if (!MD_SHORT) begin
                        state_nxt  = MD_WAIT;
                        md_cnt_nxt = MD_LOAD;
                    end
                end else if (load_use) begin
                    PcWrite      = 1'b0;
                    IfIdWrite    = 1'b0;
                    IdExFlush    = 1'b1;
                    inc_load_use = 1'b1;
                end
            end
            MD_WAIT: begin
                PcWrite     = 1'b0;
                IfIdWrite   = 1'b0;
                IdExHold    = 1'b1;
                ExMemBubble = 1'b1;
                MdBusy      = 1'b1;
                inc_md      = 1'b1;
                if (md_cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    md_cnt_nxt = md_cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt  = RUN;
                md_cnt_nxt = '0;
            end
        endcase

        // Reset drives the pipeline to a safe, fully bubbled condition.
        if (!rst_n) begin
            PcWrite      = 1'b0;
            IfIdWrite    = 1'b0;
            IfIdFlush    = 1'b1;
            IdExFlush    = 1'b1;
            IdExHold     = 1'b0;
            ExMemBubble  = 1'b1;
            MdBusy       = 1'b0;
            inc_load_use = 1'b0;
            inc_md       = 1'b0;
            inc_flush    = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counters #(
        .W (PERF_W)
    ) u_perf (
        .clk             (clk),
        .rst_n           (rst_n),
        .inc_load_use    (inc_load_use),
        .inc_md          (inc_md),
        .inc_flush       (inc_flush),
        .load_use_stalls (LoadUseStalls),
        .md_stall_cycles (MdStallCycles),
        .flush_count     (FlushCount)
    );
`else
    logic unused_perf_strobes;
    assign unused_perf_strobes = inc_load_use ^ inc_md ^ inc_flush;
    assign LoadUseStalls = '0;
    assign MdStallCycles = '0;
    assign FlushCount    = '0;
`endif

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- ID-stage hazard detection and stall controller for the 5-stage pipeline.
- Complements the forwarding path: it covers the hazards forwarding cannot resolve.
  - Load-use dependencies.
  - Multi-cycle mul/div occupancy of EX.
  - Taken-branch flushes.
- Drives PC/IF-ID write enables, ID-EX hold, and flush/bubble controls.

Parameters:
- MD_LATENCY, 4: total EX cycles a mul/div occupies (legal range 2..16).
- PERF_W, 32: width of each performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- IfIdRs  in  5  rs field of the instruction in ID.
- IfIdRt  in  5  rt field of the instruction in ID.
- IfIdUsesRt  in  1  ID instruction reads rt as a source (R-type, store, branch).
- IdExMemRead  in  1  instruction in EX is a load.
- IdExRt  in  5  load destination register of the instruction in EX.
- MdStart  in  1  instruction in EX is a mul/div, first EX cycle.
- BranchTaken  in  1  branch in EX resolved taken.
- PcWrite  out  1  PC update enable.
- IfIdWrite  out  1  IF/ID register write enable.
- IfIdFlush  out  1  clear IF/ID to NOP.
- IdExFlush  out  1  zero ID/EX control fields (bubble).
- IdExHold  out  1  hold ID/EX contents (EX re-executes).
- ExMemBubble  out  1  zero EX/MEM control fields.
- MdBusy  out  1  FSM in MD_WAIT.
- LoadUseStalls  out  PERF_W  count of load-use stall cycles.
- MdStallCycles  out  PERF_W  count of mul/div stall cycles.
- FlushCount  out  PERF_W  count of taken-branch flushes.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State RUN, md counter 0, all performance counters 0.
  - While rst_n is low, outputs are forced: PcWrite=0, IfIdWrite=0, IfIdFlush=1, IdExFlush=1, IdExHold=0, ExMemBubble=1, MdBusy=0.
- Default in RUN with no hazard: PcWrite=1, IfIdWrite=1, all flush/hold/bubble outputs 0.
- The FSM has two states, RUN and MD_WAIT. Outputs are Mealy: a function of state and inputs in the same cycle (zero latency).
- Load-use, RUN only:
  - Detected when IdExMemRead=1, IdExRt!=0, and either IdExRt==IfIdRs, or IfIdUsesRt=1 and IdExRt==IfIdRt.
  - Response: PcWrite=0, IfIdWrite=0, IdExFlush=1 for exactly one cycle.
  - The condition clears naturally once the load advances.
- Taken branch, RUN:
  - IfIdFlush=1, IdExFlush=1, PcWrite=1, IfIdWrite=1.
  - Overrides load-use in the same cycle; the load-use stall is suppressed.
- MdStart, RUN:
  - Stall this cycle: PcWrite=0, IfIdWrite=0, IdExHold=1, ExMemBubble=1.
  - If MD_LATENCY==2, stay in RUN. Otherwise load counter=MD_LATENCY-3 and go to MD_WAIT.
- MD_WAIT:
  - Same stall outputs as the MdStart cycle, plus MdBusy=1.
  - If counter==0, go to RUN next cycle; else decrement.
  - Total stall = MD_LATENCY-1 cycles, including the MdStart cycle.
  - In MD_WAIT, BranchTaken, MdStart and load-use inputs are ignored (EX is frozen).
- MdStart and BranchTaken asserted together is illegal (same EX slot).
  - Bench asserts this never happens.
  - RTL gives BranchTaken priority and does not start MD_WAIT.
- Reset asserted mid-MD_WAIT: immediate return to RUN, counter cleared.
- Counter width: clog2(MD_LATENCY). No wrap is possible within the legal range.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - LoadUseStalls increments on each load-use stall cycle.
  - MdStallCycles increments on each mul/div stall cycle (MdStart-RUN cycle and every MD_WAIT cycle).
  - FlushCount increments on each taken-branch cycle in RUN.
  - All three saturate at all-ones.
- Undefined: the three counter ports remain present and are tied to 0; no counter flops are inferred.

Decomposition:
- Shared package hazard_pkg:
  - State enum {RUN, MD_WAIT}.
  - MD counter width function.
  - Register-zero constant 5'd0.
- One natural sub-module: hazard_perf_counters, three saturating counters with increment strobes, instantiated only under HAZARD_PERF_CNT_EN.

Test Plan:
- Load-use: IdExMemRead=1, IdExRt=8, IfIdRs=8 -> one cycle of PcWrite=0, IfIdWrite=0, IdExFlush=1. Same with IfIdRt=8 and IfIdUsesRt=0 -> no stall. IdExRt=0 -> no stall.
- Branch/load-use collision: BranchTaken=1 with a load-use match -> IfIdFlush=1, IdExFlush=1, PcWrite=1. FlushCount=1, LoadUseStalls=0 (feature on).
- Mul/div, MD_LATENCY=4: MdStart pulse -> stall outputs for 3 consecutive cycles, MdBusy high on cycles 2-3, RUN on cycle 4. MdStallCycles=3.
- MD_LATENCY=2: MdStart -> single stall cycle, MdBusy never asserted.
- Reset in MD_WAIT: drop rst_n on cycle 2 of the stall -> outputs immediately at reset values. After release: RUN, no stall, counters 0.
- Feature off: repeat the load-use and branch scenarios -> all counter ports read 0.
